// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the serial FIR sequencer.
package fir_pkg;

    typedef enum logic [1:0] {StIdle, StMac, StDrain, StOut} fir_state_e;

    function automatic int unsigned acc_width(int unsigned dw, int unsigned cw,
                                              int unsigned taps);
        return dw + cw + $clog2(taps);
    endfunction

    // Arithmetic right shift (floor), then clamp to a dw-bit signed range.
    function automatic logic signed [63:0] sat_trunc(logic signed [63:0] acc,
                                                     int unsigned shift, int unsigned dw);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = acc >>> shift;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered multiply followed by a clearable accumulator (2-stage pipeline).
module fir_mac #(
    parameter int unsigned AW    = 16,
    parameter int unsigned BW    = 18,
    parameter int unsigned ACC_W = 39
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [AW-1:0]    a_i,
    input  logic signed [BW-1:0]    b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    localparam int unsigned PW = AW + BW;

    logic signed [PW-1:0]    prod_q;
    logic                    prod_vld_q;
    logic signed [ACC_W-1:0] acc_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_vld_q <= en_i;
            if (en_i) prod_q <= a_i * b_i;
            if (clr_i) begin
                acc_q <= '0;
            end else if (prod_vld_q) begin
                acc_q <= acc_q + {{(ACC_W - PW){prod_q[PW-1]}}, prod_q};
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_serial_ctrl.sv
// Single-MAC FIR sequencer: circular delay line, loadable coefficient RAM, stream handshakes.
module fir_serial_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned COEF_WIDTH = 18,
    parameter int unsigned TAP_NUM    = 28
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           s_tvalid_i,
    output logic                           s_tready_o,
    input  logic signed [DATA_WIDTH-1:0]   s_tdata_i,
    input  logic                           coef_we_i,
    input  logic [$clog2(TAP_NUM)-1:0]     coef_addr_i,
    input  logic signed [COEF_WIDTH-1:0]   coef_data_i,
    output logic                           coef_ready_o,
    output logic                           m_tvalid_o,
    input  logic                           m_tready_i,
    output logic signed [DATA_WIDTH-1:0]   m_tdata_o,
    output logic                           busy_o
);

    localparam int unsigned AddrW = $clog2(TAP_NUM);
    localparam int unsigned FillW = $clog2(TAP_NUM + 1);
    localparam int unsigned AccW  = acc_width(DATA_WIDTH, COEF_WIDTH, TAP_NUM);
    localparam logic [AddrW-1:0] LastTap = AddrW'(TAP_NUM - 1);
    localparam logic [FillW-1:0] FillMax = FillW'(TAP_NUM);

    fir_state_e               state_q, state_d;
    logic [AddrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tap_q, tap_d;
    logic [FillW-1:0]         fill_q, fill_d;
    logic                     drain_q, drain_d;
    logic                     rdy_q;
    logic                     rd_vld_q;
    logic signed [DATA_WIDTH-1:0] samp_rd_q;
    logic signed [COEF_WIDTH-1:0] coef_rd_q;
    logic signed [DATA_WIDTH-1:0] dline [TAP_NUM];
    logic signed [COEF_WIDTH-1:0] coef_mem [TAP_NUM];
    logic                     accept, coef_wr, acc_clr;
    logic signed [AccW-1:0]   acc;

    // rdy_q keeps s_tready_o low until the first edge after reset release.
    assign s_tready_o   = (state_q == StIdle) && rdy_q;
    assign coef_ready_o = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign m_tvalid_o   = (state_q == StOut);
    assign accept       = s_tvalid_i && s_tready_o;
    assign coef_wr      = coef_we_i && coef_ready_o && (32'(coef_addr_i) < TAP_NUM);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tap_d    = tap_q;
        fill_d   = fill_q;
        drain_d  = drain_q;
        acc_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rd_ptr_d = wr_ptr_q;
                    tap_d    = '0;
                    acc_clr  = 1'b1;
                    if (fill_q != FillMax) fill_d = fill_q + 1'b1;
                    state_d  = StMac;
                end
            end
            StMac: begin
                tap_d    = tap_q + 1'b1;
                rd_ptr_d = (rd_ptr_q == '0) ? LastTap : rd_ptr_q - 1'b1;
                if (tap_q == LastTap) begin
                    drain_d = 1'b0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    wr_ptr_d = (wr_ptr_q == LastTap) ? '0 : wr_ptr_q + 1'b1;
                    state_d  = StOut;
                end
            end
            StOut: begin
                if (m_tready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tap_q     <= '0;
            fill_q    <= '0;
            drain_q   <= 1'b0;
            rdy_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            samp_rd_q <= '0;
            coef_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tap_q    <= tap_d;
            fill_q   <= fill_d;
            drain_q  <= drain_d;
            rdy_q    <= 1'b1;
            rd_vld_q <= (state_q == StMac);
            if (state_q == StMac) begin
                // Slots never written since reset contribute zero.
                samp_rd_q <= (FillW'(tap_q) < fill_q) ? dline[rd_ptr_q] : '0;
                coef_rd_q <= coef_mem[tap_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) dline[wr_ptr_q] <= s_tdata_i;
        if (coef_wr) coef_mem[coef_addr_i] <= coef_data_i;
    end

    fir_mac #(
        .AW    (DATA_WIDTH),
        .BW    (COEF_WIDTH),
        .ACC_W (AccW)
    ) u_mac (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (acc_clr),
        .en_i   (rd_vld_q),
        .a_i    (samp_rd_q),
        .b_i    (coef_rd_q),
        .acc_o  (acc)
    );

    assign m_tdata_o = (state_q == StOut)
        ? DATA_WIDTH'(sat_trunc({{(64 - AccW){acc[AccW-1]}}, acc}, COEF_WIDTH - 1, DATA_WIDTH))
        : '0;

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Scoreboard bench for fir_serial_ctrl: direct-form reference model feeds an expected queue.
module tb_fir_serial_ctrl;

    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 18;
    localparam int unsigned TAPS = 28;
    localparam int unsigned AW   = $clog2(TAPS);

    logic                 clk_i = 1'b0;
    logic                 rstn_i = 1'b0;
    logic                 s_tvalid_i = 1'b0;
    logic                 s_tready_o;
    logic signed [DW-1:0] s_tdata_i = '0;
    logic                 coef_we_i = 1'b0;
    logic [AW-1:0]        coef_addr_i = '0;
    logic signed [CW-1:0] coef_data_i = '0;
    logic                 coef_ready_o;
    logic                 m_tvalid_o;
    logic                 m_tready_i = 1'b1;
    logic signed [DW-1:0] m_tdata_o;
    logic                 busy_o;

    int     n_checks = 0;
    int     n_errors = 0;
    longint exp_q[$];
    longint hist_m[$];
    longint coef_m[TAPS];
    longint last_out = 0;

    always #5 clk_i = ~clk_i;

    fir_serial_ctrl #(
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .TAP_NUM    (TAPS)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .s_tvalid_i   (s_tvalid_i),
        .s_tready_o   (s_tready_o),
        .s_tdata_i    (s_tdata_i),
        .coef_we_i    (coef_we_i),
        .coef_addr_i  (coef_addr_i),
        .coef_data_i  (coef_data_i),
        .coef_ready_o (coef_ready_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tready_i   (m_tready_i),
        .m_tdata_o    (m_tdata_o),
        .busy_o       (busy_o)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_out();
        longint acc = 0;
        longint y;
        for (int k = 0; k < hist_m.size() && k < TAPS; k++) acc += hist_m[k] * coef_m[k];
        y = acc >>> (CW - 1);
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    always @(negedge clk_i) begin
        if (rstn_i && m_tvalid_o && m_tready_i) begin
            last_out = m_tdata_o;
            if (exp_q.size() == 0) check_eq("unexpected_out", m_tvalid_o, 0);
            else check_eq("out_data", m_tdata_o, exp_q.pop_front());
        end
    end

    task automatic write_coef(input int addr, input longint val);
        int t = 0;
        while (!coef_ready_o && t < 500) begin @(negedge clk_i); t++; end
        coef_we_i   = 1'b1;
        coef_addr_i = AW'(addr);
        coef_data_i = CW'(val);
        if (addr < TAPS) coef_m[addr] = val;
        @(negedge clk_i);
        coef_we_i = 1'b0;
    endtask

    task automatic send_sample(input longint x, input bit cwe = 1'b0, input int caddr = 0,
                               input longint cval = 0);
        int t = 0;
        while (!s_tready_o && t < 500) begin @(negedge clk_i); t++; end
        if (!s_tready_o) begin
            check_eq("s_tready_timeout", s_tready_o, 1);
            return;
        end
        s_tvalid_i = 1'b1;
        s_tdata_i  = DW'(x);
        if (cwe) begin
            coef_we_i   = 1'b1;
            coef_addr_i = AW'(caddr);
            coef_data_i = CW'(cval);
            coef_m[caddr] = cval;
        end
        hist_m.push_front(x);
        if (hist_m.size() > TAPS) void'(hist_m.pop_back());
        exp_q.push_back(model_out());
        @(negedge clk_i);
        s_tvalid_i = 1'b0;
        coef_we_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy_o) && t < 3000) begin @(negedge clk_i); t++; end
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rstn_i     = 1'b0;
        s_tvalid_i = 1'b0;
        coef_we_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_s_tready", s_tready_o, 0);
        check_eq("rst_m_tvalid", m_tvalid_o, 0);
        check_eq("rst_m_tdata", m_tdata_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_coef_ready", coef_ready_o, 1);
        rstn_i = 1'b1;
        @(negedge clk_i);
        check_eq("post_rst_s_tready", s_tready_o, 1);
        hist_m.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        longint d0;

        // Basic gain: h[0..3] = 0.5, 1000 repeated
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, (k < 4) ? 65536 : 0);
        for (int i = 0; i < 4; i++) send_sample(1000);
        wait_drain();
        check_eq("t1_last", last_out, 2000);

        // Zero-fill after reset, latency, same-cycle coefficient write
        do_reset();
        send_sample(1000);
        n = 1;
        while (!m_tvalid_o && n < 200) begin @(negedge clk_i); n++; end
        check_eq("latency", n, TAPS + 3);
        wait_drain();
        check_eq("t2_first", last_out, 500);
        send_sample(2000, 1'b1, 0, 32768);
        wait_drain();
        check_eq("t2_coef_same_cycle", last_out, 1000);

        // Saturation both ways
        for (int k = 0; k < TAPS; k++) write_coef(k, 131071);
        for (int i = 0; i < 3; i++) send_sample(32767);
        wait_drain();
        check_eq("t3_sat_hi", last_out, 32767);
        for (int i = 0; i < TAPS + 2; i++) send_sample(-32768);
        wait_drain();
        check_eq("t3_sat_lo", last_out, -32768);

        // Impulse response across pointer wrap
        for (int k = 0; k < TAPS; k++) write_coef(k, k * 1000);
        for (int i = 0; i < TAPS; i++) send_sample(0);
        for (int i = 0; i < TAPS + 3; i++) send_sample((i == 0) ? 32767 : 0);
        wait_drain();

        // Backpressure in OUT: data held, no readiness, coefficient write dropped
        @(posedge clk_i); #1 m_tready_i = 1'b0;
        @(negedge clk_i);
        send_sample(1000);
        n = 0;
        while (!m_tvalid_o && n < 200) begin @(negedge clk_i); n++; end
        check_eq("t4_valid", m_tvalid_o, 1);
        d0 = m_tdata_o;
        for (int i = 0; i < 10; i++) begin
            coef_we_i   = (i == 4);
            coef_addr_i = '0;
            coef_data_i = CW'(50000);
            @(negedge clk_i);
            check_eq("t4_hold_data", m_tdata_o, d0);
            check_eq("t4_s_tready", s_tready_o, 0);
            check_eq("t4_coef_ready", coef_ready_o, 0);
        end
        coef_we_i = 1'b0;
        @(posedge clk_i); #1 m_tready_i = 1'b1;
        @(negedge clk_i);
        send_sample(3000);
        wait_drain();

        // Reset mid-MAC aborts; impulse afterwards sees clean history
        send_sample(32767);
        repeat (10) @(negedge clk_i);
        check_eq("t6_busy_mac", busy_o, 1);
        rstn_i = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check_eq("t6_abort_busy", busy_o, 0);
        check_eq("t6_abort_valid", m_tvalid_o, 0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        hist_m.delete();
        seen = 0;
        for (int i = 0; i < TAPS + 6; i++) begin
            @(negedge clk_i);
            if (m_tvalid_o) seen = 1;
        end
        check_eq("t6_no_partial", seen, 0);
        check_eq("t6_s_tready", s_tready_o, 1);
        for (int i = 0; i < TAPS + 3; i++) send_sample((i == 0) ? 32767 : 0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
